// File: rtl/sram_port_arbiter_pkg.sv
// Shared constants and helpers for the SRAM port arbiter: arbitration modes,
// kseg0/kseg1 translation and response-id sizing.
package sram_port_arbiter_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // kseg0 and kseg1 both sit in 0x8000_0000..0xBFFF_FFFF and map onto the low 512 MiB.
    localparam logic [1:0]  KSEG01_SEG     = 2'b10;
    localparam logic [31:0] KSEG_PHYS_MASK = 32'h1FFF_FFFF;

    function automatic int id_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    function automatic logic [31:0] kseg_translate(input logic [31:0] va);
        return (va[31:30] == KSEG01_SEG) ? (va & KSEG_PHYS_MASK) : va;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_rr_arbiter.sv
// Combinational one-of-N arbiter: fixed priority (lowest index) or a cyclic
// search starting at rr_ptr. The pointer itself is kept by the parent.
module rr_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int N_CH     = 2,
    parameter int ARB_MODE = ARB_RR,
    localparam int ID_W    = id_width(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [ID_W-1:0] rr_ptr,
    output logic [N_CH-1:0] gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            gnt_any
);

    logic [ID_W-1:0]   start;
    logic [2*N_CH-1:0] req_dbl;
    logic [N_CH-1:0]   req_rot;
    logic [ID_W:0]     sum;

    // NOTE: every signal driven here gets a default first, so no path leaves a latch behind.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        sum     = '0;
        start   = (ARB_MODE == ARB_RR) ? rr_ptr : '0;
        req_dbl = {req, req};
        req_rot = N_CH'(req_dbl >> start);
        // Rotated view puts the start channel at bit 0; undo the rotation on the winner.
        for (int i = 0; i < N_CH; i++) begin
            if (!gnt_any && req_rot[i]) begin
                gnt_any = 1'b1;
                sum     = {1'b0, start} + (ID_W+1)'(i);
                if (sum >= (ID_W+1)'(N_CH)) begin
                    sum = sum - (ID_W+1)'(N_CH);
                end
                gnt_id = sum[ID_W-1:0];
            end
        end
        gnt = gnt_any ? (N_CH'(1) << gnt_id) : '0;
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// N-channel arbiter sharing one synchronous SRAM port, with inline kseg
// translation and an in-order, latency-matched read response pipeline.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int N_CH     = 2,
    parameter int MEM_LAT  = 1,
    parameter int ARB_MODE = ARB_RR,
    parameter int MMU_EN   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH-1:0]      ch_req,
    input  logic [4*N_CH-1:0]    ch_wen,
    input  logic [32*N_CH-1:0]   ch_addr,
    input  logic [32*N_CH-1:0]   ch_wdata,
    output logic [N_CH-1:0]      ch_gnt,
    output logic [N_CH-1:0]      ch_rvalid,
    output logic [31:0]          ch_rdata,
    output logic                 mem_en,
    output logic [3:0]           mem_wen,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata
);

    localparam int ID_W = id_width(N_CH);

    logic [N_CH-1:0]  req_live;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  gnt_id;
    logic             gnt_any;
    logic [31:0]      sel_addr;
    logic             rd_accept;
    logic [MEM_LAT-1:0] pipe_vld;
    logic [ID_W-1:0]  pipe_id [MEM_LAT];

    // Requests are masked while reset is high so nothing reaches the SRAM.
    assign req_live = rst ? '0 : ch_req;

    rr_arbiter #(
        .N_CH     (N_CH),
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .req     (req_live),
        .rr_ptr  (rr_ptr),
        .gnt     (ch_gnt),
        .gnt_id  (gnt_id),
        .gnt_any (gnt_any)
    );

    always_comb begin
        mem_wen   = '0;
        sel_addr  = '0;
        mem_wdata = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (ch_gnt[k]) begin
                mem_wen   = ch_wen[k*4 +: 4];
                sel_addr  = ch_addr[k*32 +: 32];
                mem_wdata = ch_wdata[k*32 +: 32];
            end
        end
        mem_en    = gnt_any;
        mem_addr  = (MMU_EN != 0) ? kseg_translate(sel_addr) : sel_addr;
        rd_accept = gnt_any && (mem_wen == 4'b0000);
    end

    // NOTE: state registers use non-blocking assignments so every stage samples the pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            pipe_vld <= '0;
            // NOTE: the id stages are reset too; the array is only MEM_LAT deep and this keeps X off ch_rvalid.
            for (int s = 0; s < MEM_LAT; s++) begin
                pipe_id[s] <= '0;
            end
        end else begin
            if (ARB_MODE == ARB_RR && gnt_any) begin
                rr_ptr <= (int'(gnt_id) == N_CH - 1) ? '0 : gnt_id + 1'b1;
            end
            pipe_vld[0] <= rd_accept;
            pipe_id[0]  <= gnt_id;
            for (int s = 1; s < MEM_LAT; s++) begin
                pipe_vld[s] <= pipe_vld[s-1];
                pipe_id[s]  <= pipe_id[s-1];
            end
        end
    end

    assign ch_rvalid = pipe_vld[MEM_LAT-1] ? (N_CH'(1) << pipe_id[MEM_LAT-1]) : '0;
    assign ch_rdata  = pipe_vld[MEM_LAT-1] ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Drives two arbiter configurations from shared stimulus and compares both
// against a queue-based reference model of grants, translation and responses.
module tb_sram_port_arbiter;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    ch_req = '0;
    logic [15:0]   ch_wen = '0;
    logic [127:0]  ch_addr = '0;
    logic [127:0]  ch_wdata = '0;
    logic [31:0]   mem_rdata = '0;

    // Config A: 4 channels, latency 3, round-robin, translation on.
    logic [3:0]  a_gnt, a_rvalid, a_mem_wen;
    logic [31:0] a_rdata, a_mem_addr, a_mem_wdata;
    logic        a_mem_en;
    // Config B: 2 channels (channels 0..1 of the shared stimulus), latency 1, fixed, no translation.
    logic [1:0]  b_gnt, b_rvalid;
    logic [3:0]  b_mem_wen;
    logic [31:0] b_rdata, b_mem_addr, b_mem_wdata;
    logic        b_mem_en;

    always #5 clk = ~clk;

    sram_port_arbiter #(.N_CH(4), .MEM_LAT(3), .ARB_MODE(1), .MMU_EN(1)) dut_a (
        .clk(clk), .rst(rst), .ch_req(ch_req), .ch_wen(ch_wen), .ch_addr(ch_addr),
        .ch_wdata(ch_wdata), .ch_gnt(a_gnt), .ch_rvalid(a_rvalid), .ch_rdata(a_rdata),
        .mem_en(a_mem_en), .mem_wen(a_mem_wen), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata)
    );

    sram_port_arbiter #(.N_CH(2), .MEM_LAT(1), .ARB_MODE(0), .MMU_EN(0)) dut_b (
        .clk(clk), .rst(rst), .ch_req(ch_req[1:0]), .ch_wen(ch_wen[7:0]), .ch_addr(ch_addr[63:0]),
        .ch_wdata(ch_wdata[63:0]), .ch_gnt(b_gnt), .ch_rvalid(b_rvalid), .ch_rdata(b_rdata),
        .mem_en(b_mem_en), .mem_wen(b_mem_wen), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata)
    );

    typedef struct {
        int due;
        int id;
    } resp_t;

    resp_t qa[$];
    resp_t qb[$];
    int    ptr_a = 0;
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // First requesting channel at or after ptr, cyclic; -1 when idle.
    function automatic int pick(input logic [3:0] req, input int n, input int ptr);
        for (int i = 0; i < n; i++) begin
            if (req[(ptr + i) % n]) return (ptr + i) % n;
        end
        return -1;
    endfunction

    function automatic logic [31:0] xlate(input logic [31:0] va, input bit mmu);
        if (mmu && va >= 32'h8000_0000 && va <= 32'hBFFF_FFFF) return va % 32'h2000_0000;
        return va;
    endfunction

    task automatic run_cycle(input logic [3:0] req, input logic [15:0] wen,
                             input logic [127:0] addr, input logic [127:0] wdata,
                             input logic [31:0] rdata);
        int          ga;
        int          gb;
        resp_t       r;
        logic [3:0]  w;
        @(negedge clk);
        ch_req = req; ch_wen = wen; ch_addr = addr; ch_wdata = wdata; mem_rdata = rdata;
        #1;
        // Config A
        ga = pick(req, 4, ptr_a);
        check("a_gnt", 32'(a_gnt), (ga >= 0) ? (32'd1 << ga) : 32'd0);
        check("a_mem_en", 32'(a_mem_en), 32'(ga >= 0));
        if (ga >= 0) begin
            w = 4'(wen >> (ga * 4));
            check("a_mem_wen", 32'(a_mem_wen), 32'(w));
            check("a_mem_addr", a_mem_addr, xlate(32'(addr >> (ga * 32)), 1'b1));
            check("a_mem_wdata", a_mem_wdata, 32'(wdata >> (ga * 32)));
        end else begin
            w = 4'hF;
            check("a_mem_wen_idle", 32'(a_mem_wen), 32'd0);
        end
        if (qa.size() > 0 && qa[0].due == cyc) begin
            r = qa.pop_front();
            check("a_rvalid", 32'(a_rvalid), 32'd1 << r.id);
            check("a_rdata", a_rdata, rdata);
        end else begin
            check("a_rvalid_idle", 32'(a_rvalid), 32'd0);
            check("a_rdata_idle", a_rdata, 32'd0);
        end
        if (ga >= 0) begin
            ptr_a = (ga + 1) % 4;
            if (w == 4'h0) qa.push_back('{cyc + 3, ga});
        end
        // Config B
        gb = pick(req, 2, 0);
        check("b_gnt", 32'(b_gnt), (gb >= 0) ? (32'd1 << gb) : 32'd0);
        check("b_mem_en", 32'(b_mem_en), 32'(gb >= 0));
        if (gb >= 0) begin
            w = 4'(wen >> (gb * 4));
            check("b_mem_wen", 32'(b_mem_wen), 32'(w));
            check("b_mem_addr", b_mem_addr, xlate(32'(addr >> (gb * 32)), 1'b0));
            check("b_mem_wdata", b_mem_wdata, 32'(wdata >> (gb * 32)));
        end else begin
            w = 4'hF;
            check("b_mem_wen_idle", 32'(b_mem_wen), 32'd0);
        end
        if (qb.size() > 0 && qb[0].due == cyc) begin
            r = qb.pop_front();
            check("b_rvalid", 32'(b_rvalid), 32'd1 << r.id);
            check("b_rdata", b_rdata, rdata);
        end else begin
            check("b_rvalid_idle", 32'(b_rvalid), 32'd0);
            check("b_rdata_idle", b_rdata, 32'd0);
        end
        if (gb >= 0 && w == 4'h0) qb.push_back('{cyc + 1, gb});
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(4'h0, 16'h0, 128'h0, 128'h0, $urandom);
    endtask

    // Reset is raised mid-cycle with every channel requesting; all outputs must read 0.
    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        ch_req = 4'hF; ch_wen = 16'h0;
        ch_addr = {$urandom, $urandom, $urandom, $urandom};
        mem_rdata = $urandom;
        #1;
        check("rst_a_gnt", 32'(a_gnt), 32'd0);
        check("rst_a_mem_en", 32'(a_mem_en), 32'd0);
        check("rst_a_mem_wen", 32'(a_mem_wen), 32'd0);
        check("rst_a_mem_addr", a_mem_addr, 32'd0);
        check("rst_a_mem_wdata", a_mem_wdata, 32'd0);
        check("rst_a_rvalid", 32'(a_rvalid), 32'd0);
        check("rst_a_rdata", a_rdata, 32'd0);
        check("rst_b_gnt", 32'(b_gnt), 32'd0);
        check("rst_b_mem_en", 32'(b_mem_en), 32'd0);
        check("rst_b_rvalid", 32'(b_rvalid), 32'd0);
        check("rst_b_rdata", b_rdata, 32'd0);
        qa.delete();
        qb.delete();
        ptr_a = 0;
        @(negedge clk);
        rst = 1'b0;
        ch_req = 4'h0;
        cyc += 2;
    endtask

    initial begin
        logic [15:0]  rw;
        logic [127:0] ra;
        logic [127:0] rd;

        pulse_reset();

        // Single read through kseg0 on channel 0, data returned next cycle on B.
        run_cycle(4'b0001, 16'h0, {96'h0, 32'h8000_0100}, 128'h0, $urandom);
        run_cycle(4'b0000, 16'h0, 128'h0, 128'h0, 32'hDEAD_BEEF);
        idle(3);

        // Continuous contention between channels 0 and 1 from a fresh pointer.
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            run_cycle(4'b0011, 16'h0, {64'h0, 32'h8000_0200, 32'h8000_0300}, 128'h0, $urandom);
        end
        idle(4);

        // Partial write from channel 1 through kseg1: no response expected.
        run_cycle(4'b0010, 16'h0030, {64'h0, 32'hA000_0040, 32'h0}, {64'h0, 32'h1234_5678, 32'h0}, $urandom);
        idle(4);

        // Back-to-back reads from channels 2, 0, 3.
        run_cycle(4'b0100, 16'h0, {32'h0, 32'h8000_1000, 64'h0}, 128'h0, $urandom);
        run_cycle(4'b0001, 16'h0, {96'h0, 32'h0000_2000}, 128'h0, $urandom);
        run_cycle(4'b1000, 16'h0, {32'hBFC0_0010, 96'h0}, 128'h0, $urandom);
        idle(4);

        // Reset while a read is in flight, then all channels contend.
        run_cycle(4'b0001, 16'h0, {96'h0, 32'h8000_0400}, 128'h0, $urandom);
        pulse_reset();
        run_cycle(4'b1111, 16'h0, {32'h3, 32'h2, 32'h1, 32'h0}, 128'h0, $urandom);
        idle(4);

        // Passthrough addresses: useg on A, kseg0 untouched on B.
        run_cycle(4'b0001, 16'h0, {96'h0, 32'h1FC0_0000}, 128'h0, $urandom);
        run_cycle(4'b0010, 16'h0, {64'h0, 32'h8000_0000, 32'h0}, 128'h0, $urandom);
        idle(4);

        // Randomised traffic: mixed reads/writes across all address segments.
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 4; k++) begin
                rw[k*4 +: 4]   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                ra[k*32 +: 32] = {2'($urandom_range(0, 3)), 30'($urandom)};
                rd[k*32 +: 32] = $urandom;
            end
            run_cycle(4'($urandom), rw, ra, rd, $urandom);
            if (n == 200) pulse_reset();
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
